// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO family.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fifo_pkg;

    localparam int FIFO_DEF_WIDTH = 32;
    localparam int FIFO_DEF_DEPTH = 32;

    // Unsigned size type used for pointer and count width arithmetic.
    typedef int unsigned fifo_size_t;

    // Bits needed to hold an occupancy of 0..depth inclusive.
    function automatic fifo_size_t cnt_width(input fifo_size_t depth);
        return fifo_size_t'($clog2(depth + 1));
    endfunction

    // Pointer increment with explicit wrap at depth-1; works for any depth.
    function automatic fifo_size_t ptr_inc(input fifo_size_t ptr, input fifo_size_t depth);
        return (ptr == depth - 1) ? fifo_size_t'(0) : ptr + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x WIDTH storage: one synchronous write port, one registered read port.
// Latency: read data appears the cycle after re is sampled; write lands at the edge.
// Backpressure: none; the caller gates we/re. byp forwards wdata into the read register.
module sync_fifo_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    input  logic                     byp,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage array: written only, never reset, so contents survive Rst.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read register: cleared on reset, loads only when re, holds otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= byp ? wdata : mem[raddr];
        end
    end

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO with thresholds, occupancy count and error pulses.
// Latency: 1 cycle registered read; flags/Count reflect the post-edge state. FIFO_FWFT_EN selects first-word-fall-through.
// Backpressure: writes dropped when FULL (OVF), reads refused when EMPTY (UDF); EN=0 freezes all state.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH     = FIFO_DEF_WIDTH,
    parameter int DEPTH     = FIFO_DEF_DEPTH,
    parameter int AF_THRESH = DEPTH - 4,
    parameter int AE_THRESH = 4
) (
    input  logic                           Clk,
    input  logic                           Rst,
    input  logic                           EN,
    input  logic                           WR,
    input  logic [WIDTH-1:0]               dataIn,
    input  logic                           RD,
    output logic [WIDTH-1:0]               dataOut,
    output logic                           EMPTY,
    output logic                           FULL,
    output logic                           ALMOST_EMPTY,
    output logic                           ALMOST_FULL,
    output logic [cnt_width(DEPTH)-1:0]    Count,
    output logic                           OVF,
    output logic                           UDF
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = int'(cnt_width(DEPTH));

    logic [PW-1:0] rptr;
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr_nxt;
    logic [PW-1:0] wptr_nxt;
    logic [CW-1:0] count_nxt;
    logic          act;
    logic          rd_ok;
    logic          wr_ok;
    logic          mem_re;
    logic          mem_byp;
    logic [PW-1:0] mem_raddr;

    // Accept decisions, next pointers and the up/down occupancy counter.
    always_comb begin
        act      = EN & ~Rst;
        rd_ok    = act & RD & ~EMPTY;
        // A read in the same cycle frees a slot, so a full FIFO still takes the write.
        wr_ok    = act & WR & (~FULL | rd_ok);
        rptr_nxt = rd_ok ? PW'(ptr_inc(fifo_size_t'(rptr), fifo_size_t'(DEPTH))) : rptr;
        wptr_nxt = wr_ok ? PW'(ptr_inc(fifo_size_t'(wptr), fifo_size_t'(DEPTH))) : wptr;
        count_nxt = Count;
        if (wr_ok && !rd_ok) begin
            count_nxt = Count + CW'(1);
        end else if (rd_ok && !wr_ok) begin
            count_nxt = Count - CW'(1);
        end
    end

    // Read-port control: standard pops on rd_ok; FWFT keeps the head word presented.
    always_comb begin
`ifdef FIFO_FWFT_EN
        // Refresh the output register with the next head whenever the FIFO changes and stays non-empty.
        mem_re    = (rd_ok | wr_ok) & (count_nxt != '0);
        mem_raddr = rptr_nxt;
        // The new head is the word being written this very edge; memory doesn't hold it yet.
        mem_byp   = wr_ok & (rptr_nxt == wptr);
`else
        mem_re    = rd_ok;
        mem_raddr = rptr;
        mem_byp   = 1'b0;
`endif
    end

    // Pointers, count, registered flags and one-cycle error pulses.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            rptr         <= '0;
            wptr         <= '0;
            Count        <= '0;
            EMPTY        <= 1'b1;
            FULL         <= 1'b0;
            ALMOST_EMPTY <= 1'b1;
            ALMOST_FULL  <= (AF_THRESH == 0);
            OVF          <= 1'b0;
            UDF          <= 1'b0;
        end else if (EN) begin
            rptr         <= rptr_nxt;
            wptr         <= wptr_nxt;
            Count        <= count_nxt;
            EMPTY        <= (count_nxt == '0);
            FULL         <= (count_nxt == CW'(DEPTH));
            ALMOST_EMPTY <= (int'(count_nxt) <= AE_THRESH);
            ALMOST_FULL  <= (int'(count_nxt) >= AF_THRESH);
            OVF          <= WR & ~wr_ok;
            UDF          <= RD & ~rd_ok;
        end else begin
            OVF          <= 1'b0;
            UDF          <= 1'b0;
        end
    end

    sync_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (Clk),
        .rst   (Rst),
        .we    (wr_ok),
        .waddr (wptr),
        .wdata (dataIn),
        .re    (mem_re),
        .raddr (mem_raddr),
        .byp   (mem_byp),
        .rdata (dataOut)
    );

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench for sync_fifo_param: a DEPTH=32 instance and a DEPTH=5 instance.
// A queue model predicts accepted data, Count, flags and error pulses.
// Outputs are sampled 1 time unit after each rising edge.
module tb_sync_fifo_param;

    logic        Clk = 1'b0;
    logic        Rst, EN, WR, RD;
    logic [31:0] dataIn, dataOut;
    logic        EMPTY, FULL, AE, AF, OVF, UDF;
    logic [5:0]  Count;

    logic        rst5, en5, wr5, rd5;
    logic [7:0]  din5, dout5;
    logic        e5, f5, ae5, af5, ovf5, udf5;
    logic [2:0]  cnt5;

    int checks = 0;
    int errors = 0;

    logic [31:0] q[$];
    logic [31:0] m_dout;
    bit          m_ovf, m_udf;

    logic [7:0]  q5[$];
    logic [7:0]  m5_dout;
    bit          m5_ovf;

    always #5 Clk = ~Clk;

    sync_fifo_param #(.WIDTH(32), .DEPTH(32), .AF_THRESH(28), .AE_THRESH(4)) u_dut (
        .Clk(Clk), .Rst(Rst), .EN(EN), .WR(WR), .dataIn(dataIn), .RD(RD),
        .dataOut(dataOut), .EMPTY(EMPTY), .FULL(FULL), .ALMOST_EMPTY(AE),
        .ALMOST_FULL(AF), .Count(Count), .OVF(OVF), .UDF(UDF)
    );

    sync_fifo_param #(.WIDTH(8), .DEPTH(5), .AF_THRESH(4), .AE_THRESH(1)) u_dut5 (
        .Clk(Clk), .Rst(rst5), .EN(en5), .WR(wr5), .dataIn(din5), .RD(rd5),
        .dataOut(dout5), .EMPTY(e5), .FULL(f5), .ALMOST_EMPTY(ae5),
        .ALMOST_FULL(af5), .Count(cnt5), .OVF(ovf5), .UDF(udf5)
    );

    // Drive one cycle on the 32-deep instance and advance the reference model.
    task automatic cyc(input bit en, input bit rst, input bit wr, input bit rd, input logic [31:0] din);
        bit rok, wok;
        EN = en; Rst = rst; WR = wr; RD = rd; dataIn = din;
        m_ovf = 0; m_udf = 0;
        if (rst) begin
            q.delete();
            m_dout = '0;
        end else if (en) begin
            rok = rd && (q.size() != 0);
            wok = wr && ((q.size() < 32) || rok);
            if (rok) m_dout = q.pop_front();
            if (wok) q.push_back(din);
            m_ovf = wr && !wok;
            m_udf = rd && !rok;
        end
        @(posedge Clk); #1;
    endtask

    // Drive one cycle on the 5-deep instance and advance its model.
    task automatic cyc5(input bit rst, input bit wr, input bit rd, input logic [7:0] din);
        bit rok, wok;
        en5 = 1'b1; rst5 = rst; wr5 = wr; rd5 = rd; din5 = din;
        m5_ovf = 0;
        if (rst) begin
            q5.delete();
            m5_dout = '0;
        end else begin
            rok = rd && (q5.size() != 0);
            wok = wr && ((q5.size() < 5) || rok);
            if (rok) m5_dout = q5.pop_front();
            if (wok) q5.push_back(din);
            m5_ovf = wr && !wok;
        end
        @(posedge Clk); #1;
    endtask

    function automatic logic [3:0] exp_flags();
        return {q.size() == 0, q.size() == 32, q.size() <= 4, q.size() >= 28};
    endfunction

    task automatic test_reset();
        cyc(1, 1, 1, 1, 32'h1234);
        cyc(1, 0, 0, 0, 32'h0);
        checks++; if (dataOut !== 32'h0) begin errors++; $display("FAIL reset_dout got %h want 0", dataOut); end
        checks++; if ({EMPTY, FULL, AE, AF} !== 4'b1010) begin errors++; $display("FAIL reset_flags got %b want 1010", {EMPTY, FULL, AE, AF}); end
        checks++; if (Count !== 6'd0) begin errors++; $display("FAIL reset_count got %0d want 0", Count); end
        checks++; if ({OVF, UDF} !== 2'b00) begin errors++; $display("FAIL reset_pulses got %b want 00", {OVF, UDF}); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 32; i++) begin
            cyc(1, 0, 1, 0, 32'h1000 + i);
            checks++; if (Count !== 6'(q.size())) begin errors++; $display("FAIL fill_count i=%0d got %0d want %0d", i, Count, q.size()); end
            checks++; if ({EMPTY, FULL, AE, AF} !== exp_flags()) begin errors++; $display("FAIL fill_flags i=%0d got %b want %b", i, {EMPTY, FULL, AE, AF}, exp_flags()); end
        end
        cyc(1, 0, 1, 0, 32'hDEAD);
        checks++; if (OVF !== m_ovf || OVF !== 1'b1) begin errors++; $display("FAIL overflow_pulse got %b want 1", OVF); end
        checks++; if (Count !== 6'd32 || FULL !== 1'b1) begin errors++; $display("FAIL overflow_count got %0d/%b want 32/1", Count, FULL); end
        cyc(1, 0, 0, 0, 32'h0);
        checks++; if (OVF !== 1'b0) begin errors++; $display("FAIL overflow_single got %b want 0", OVF); end
    endtask

    task automatic test_full_rw();
        cyc(1, 0, 1, 1, 32'hCAFE);
        checks++; if (dataOut !== m_dout || dataOut !== 32'h1000) begin errors++; $display("FAIL full_rw_dout got %h want 1000", dataOut); end
        checks++; if (Count !== 6'd32 || OVF !== 1'b0) begin errors++; $display("FAIL full_rw_count got %0d ovf %b want 32 ovf 0", Count, OVF); end
        for (int i = 0; i < 32; i++) begin
            cyc(1, 0, 0, 1, 32'h0);
            checks++; if (dataOut !== m_dout) begin errors++; $display("FAIL drain_dout i=%0d got %h want %h", i, dataOut, m_dout); end
            checks++; if ({EMPTY, FULL, AE, AF} !== exp_flags()) begin errors++; $display("FAIL drain_flags i=%0d got %b want %b", i, {EMPTY, FULL, AE, AF}, exp_flags()); end
        end
        checks++; if (dataOut !== 32'hCAFE || Count !== 6'd0) begin errors++; $display("FAIL drain_last got %h/%0d want cafe/0", dataOut, Count); end
        cyc(1, 0, 0, 1, 32'h0);
        checks++; if (UDF !== m_udf || UDF !== 1'b1) begin errors++; $display("FAIL underflow_pulse got %b want 1", UDF); end
        checks++; if (dataOut !== 32'hCAFE) begin errors++; $display("FAIL underflow_hold got %h want cafe", dataOut); end
    endtask

    task automatic test_empty_rw();
        cyc(1, 0, 1, 1, 32'hA5);
        checks++; if (UDF !== m_udf || UDF !== 1'b1) begin errors++; $display("FAIL empty_rw_udf got %b want 1", UDF); end
        checks++; if (Count !== 6'd1 || EMPTY !== 1'b0) begin errors++; $display("FAIL empty_rw_count got %0d/%b want 1/0", Count, EMPTY); end
        checks++; if (dataOut !== m_dout) begin errors++; $display("FAIL empty_rw_hold got %h want %h", dataOut, m_dout); end
        cyc(1, 0, 0, 1, 32'h0);
        checks++; if (dataOut !== 32'hA5 || dataOut !== m_dout) begin errors++; $display("FAIL empty_rw_read got %h want a5", dataOut); end
    endtask

    task automatic test_enable();
        for (int i = 0; i < 11; i++) cyc(1, 0, 1, 0, 32'h200 + i);
        cyc(1, 0, 0, 1, 32'h0);
        checks++; if (Count !== 6'd10 || dataOut !== 32'h200) begin errors++; $display("FAIL enable_setup got %0d/%h want 10/200", Count, dataOut); end
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, i[0], ~i[0], $urandom);
            checks++; if (Count !== 6'd10 || Count !== 6'(q.size())) begin errors++; $display("FAIL enable_count i=%0d got %0d want 10", i, Count); end
            checks++; if (dataOut !== m_dout) begin errors++; $display("FAIL enable_dout i=%0d got %h want %h", i, dataOut, m_dout); end
            checks++; if ({OVF, UDF} !== 2'b00) begin errors++; $display("FAIL enable_pulses i=%0d got %b want 00", i, {OVF, UDF}); end
        end
        cyc(0, 1, 1, 1, 32'h0);
        checks++; if (Count !== 6'd0 || EMPTY !== 1'b1) begin errors++; $display("FAIL enable_reset got %0d/%b want 0/1", Count, EMPTY); end
        checks++; if (dataOut !== 32'h0) begin errors++; $display("FAIL enable_reset_dout got %h want 0", dataOut); end
    endtask

    task automatic test_depth5();
        cyc5(1, 0, 0, 8'h0);
        for (int i = 0; i < 12; i++) begin
            cyc5(0, 1, (i % 3) == 2, 8'h40 + 8'(i));
            checks++; if (cnt5 !== 3'(q5.size()) || cnt5 > 3'd5) begin errors++; $display("FAIL d5_count i=%0d got %0d want %0d", i, cnt5, q5.size()); end
            checks++; if (f5 !== (q5.size() == 5)) begin errors++; $display("FAIL d5_full i=%0d got %b want %b", i, f5, q5.size() == 5); end
            checks++; if (dout5 !== m5_dout || ovf5 !== m5_ovf) begin errors++; $display("FAIL d5_out i=%0d got %h/%b want %h/%b", i, dout5, ovf5, m5_dout, m5_ovf); end
        end
        for (int i = 0; i < 5; i++) begin
            cyc5(0, 0, 1, 8'h0);
            checks++; if (dout5 !== m5_dout) begin errors++; $display("FAIL d5_drain i=%0d got %h want %h", i, dout5, m5_dout); end
        end
        checks++; if (e5 !== 1'b1 || cnt5 !== 3'd0) begin errors++; $display("FAIL d5_empty got %b/%0d want 1/0", e5, cnt5); end
    endtask

    task automatic test_fwft();
        cyc(1, 1, 0, 0, 32'h0);
        EN = 1; Rst = 0; WR = 1; RD = 0; dataIn = 32'h77;
        @(posedge Clk); #1;
        WR = 0;
        @(posedge Clk); #1;
        checks++; if (dataOut !== 32'h77) begin errors++; $display("FAIL fwft_dout got %h want 77", dataOut); end
        checks++; if (EMPTY !== 1'b0 || Count !== 6'd1) begin errors++; $display("FAIL fwft_state got %b/%0d want 0/1", EMPTY, Count); end
        RD = 1;
        @(posedge Clk); #1;
        RD = 0;
        checks++; if (EMPTY !== 1'b1 || Count !== 6'd0) begin errors++; $display("FAIL fwft_pop got %b/%0d want 1/0", EMPTY, Count); end
    endtask

    initial begin
        Rst = 1; EN = 0; WR = 0; RD = 0; dataIn = '0;
        rst5 = 1; en5 = 0; wr5 = 0; rd5 = 0; din5 = '0;
        m_dout = '0; m5_dout = '0;
        test_reset();
`ifdef FIFO_FWFT_EN
        test_fwft();
`else
        test_fill();
        test_full_rw();
        test_empty_rw();
        test_enable();
        test_depth5();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
